// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, grant encoding and
// a helper that turns a grant into a one-hot port mask.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // bit 0 = fetch port, bit 1 = data port
  function automatic logic [1:0] port_mask(input grant_e g);
    return (g == GNT_I) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side fetch/data ports and SRAM pins of the arbiter, bundled as one interface.
// slave = arbiter view, master = surrounding cpu/board view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce;
  logic              mem_oe;
  logic              mem_we;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    output i_data, i_ready, d_rdata, d_ready,
    output mem_addr, mem_wdata, mem_ce, mem_oe, mem_we
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
    input  i_data, i_ready, d_rdata, d_ready,
    input  mem_addr, mem_wdata, mem_ce, mem_oe, mem_we
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational round-robin picker between the fetch and data ports.
// A port in the exclude mask is treated as not requesting.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       fetch_req_i,
  input  logic       data_req_i,
  input  grant_e     last_grant_i,
  input  logic [1:0] exclude_i,
  output logic       any_o,
  output grant_e     grant_o
);

  logic fetch_ok;
  logic data_ok;

  assign fetch_ok = fetch_req_i && !exclude_i[0];
  assign data_ok  = data_req_i && !exclude_i[1];
  assign any_o    = fetch_ok || data_ok;

  always_comb begin
    grant_o = GNT_I;
    if (fetch_ok && data_ok) begin
      grant_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
    end else if (data_ok) begin
      grant_o = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data ports, sequencing
// SETUP / ACCESS (WAIT_CYCLES) / HOLD with registered strobes and a one-cycle ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q;
  grant_e            gnt_q;
  grant_e            last_gnt_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ce_q;
  logic              oe_q;
  logic              we_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] i_data_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              pick_any;
  grant_e            pick_gnt;
  logic [1:0]        exclude;

  // The port finishing in HOLD still has its request up; keep it out of the pick.
  assign exclude = (state_q == ST_HOLD) ? port_mask(gnt_q) : 2'b00;

  mem_arb_pick u_pick (
    .fetch_req_i  (bus.i_req),
    .data_req_i   (bus.d_read | bus.d_write),
    .last_grant_i (last_gnt_q),
    .exclude_i    (exclude),
    .any_o        (pick_any),
    .grant_o      (pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_I;
      last_gnt_q <= GNT_D;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ce_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      i_data_q   <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          oe_q <= 1'b0;
          we_q <= 1'b0;
          if (pick_any) begin
            state_q    <= ST_SETUP;
            gnt_q      <= pick_gnt;
            last_gnt_q <= pick_gnt;
            ce_q       <= 1'b1;
            if (pick_gnt == GNT_I) begin
              addr_q <= bus.i_addr;
              wr_q   <= 1'b0;
            end else begin
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
              wr_q    <= bus.d_write;   // read+write together is a write
            end
          end else begin
            state_q <= ST_IDLE;
            ce_q    <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_q <= ST_ACCESS;
          cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
          oe_q    <= ~wr_q;
          we_q    <= wr_q;
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            if (gnt_q == GNT_I) begin
              i_ready_q <= 1'b1;
              i_data_q  <= bus.mem_rdata;
            end else begin
              d_ready_q <= 1'b1;
              if (!wr_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ce_q    <= 1'b0;
          oe_q    <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_ce    = ce_q;
  assign bus.mem_oe    = oe_q;
  assign bus.mem_we    = we_q;
  assign bus.i_data    = i_data_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM behavioural model on the pins, transaction-level reference
// (shadow memory + round-robin winner) and directed/randomized scenarios for WAIT_CYCLES=2 and 1.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int W  = 2;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W))  dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests_run    = 0;
  int tests_failed = 0;

  // Power-up SRAM contents; 0x0010 holds the word fetched in the first scenario.
  function automatic logic [15:0] init_pat(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a ^ 16'hA5A5) + {a[7:0], a[15:8]};
  endfunction

  logic [15:0] sram    [0:65535];
  logic        written [0:65535];
  assign bus.mem_rdata  = !bus.mem_oe ? 16'h0BAD :
                          ((written[bus.mem_addr] === 1'b1) ? sram[bus.mem_addr] : init_pat(bus.mem_addr));
  assign bus1.mem_rdata = bus1.mem_oe ? init_pat(bus1.mem_addr) : 16'h0BAD;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      sram[bus.mem_addr]    <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  // Reference model: memory contents as seen by the CPU and the last winner (0=fetch, 1=data).
  logic [15:0] shadow [logic [15:0]];
  int model_last  = 1;
  int model_last1 = 1;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_pat(a);
  endfunction

  // Observation record filled by observe()
  int ob_ce, ob_oe, ob_we, ob_viol, ob_gap;
  int ob_port [$];
  int ob_cyc [$];
  logic [15:0] ob_data [$];
  logic [15:0] ob_addr [$];
  logic [15:0] ob_wd [$];

  task automatic observe(input int n_done, input int budget, input bit keep, input bit scramble);
    logic prev_ce;
    bit   started;
    ob_ce = 0; ob_oe = 0; ob_we = 0; ob_viol = 0; ob_gap = 0;
    ob_port.delete(); ob_cyc.delete(); ob_data.delete(); ob_addr.delete(); ob_wd.delete();
    prev_ce = bus.mem_ce;
    started = 0;
    for (int k = 1; k <= budget && ob_port.size() < n_done; k++) begin
      @(negedge clk);
      if (bus.mem_ce) begin
        ob_ce++; started = 1; ob_addr.push_back(bus.mem_addr);
      end else if (started) begin
        ob_gap++;
      end
      if (bus.mem_oe) ob_oe++;
      if (bus.mem_we) begin
        ob_we++; ob_wd.push_back(bus.mem_wdata);
      end
      if (bus.i_ready && bus.d_ready) ob_viol++;
      if (bus.mem_we && !prev_ce) ob_viol++;
      if (bus.mem_oe && bus.mem_we) ob_viol++;
      if ((bus.i_ready || bus.d_ready) && (!bus.mem_ce || bus.mem_oe || bus.mem_we)) ob_viol++;
      prev_ce = bus.mem_ce;
      if (bus.i_ready) begin
        ob_port.push_back(0); ob_cyc.push_back(k); ob_data.push_back(bus.i_data);
        if (!keep) bus.i_req = 1'b0;
      end
      if (bus.d_ready) begin
        ob_port.push_back(1); ob_cyc.push_back(k); ob_data.push_back(bus.d_rdata);
        if (!keep) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      end
      if (keep && ob_port.size() >= n_done) begin
        bus.i_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
      if (scramble && k == 2) begin
        bus.i_addr  = 16'($urandom);
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 16'h1234;
    bus.d_read = 1'b0; bus.d_write = 1'b1; bus.d_addr = 16'h4321; bus.d_wdata = 16'h5555;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_read = 1'b0; bus1.d_write = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.mem_ce, bus.mem_oe, bus.mem_we, bus.i_ready, bus.d_ready} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got ce/oe/we/ir/dr=%b expected 00000",
               {bus.mem_ce, bus.mem_oe, bus.mem_we, bus.i_ready, bus.d_ready});
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h idata=%h drdata=%h expected all 0",
               bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata);
    end
    bus.i_req = 1'b0; bus.d_write = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_ce !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got ce=%b expected 0", bus.mem_ce);
    end
    model_last = 1; model_last1 = 1;
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_single_fetch();
    repeat (2) @(negedge clk);
    bus.i_addr = 16'h0010; bus.i_req = 1'b1;
    observe(1, 20, 0, 0);
    tests_run++;
    if (ob_port.size() != 1 || ob_port[0] != 0 || ob_cyc[0] != W + 2) begin
      tests_failed++;
      $display("FAIL fetch_latency: got %0d events (first port/cycle %0d/%0d) expected 1 fetch at %0d",
               ob_port.size(), ob_port.size() > 0 ? ob_port[0] : -1, ob_cyc.size() > 0 ? ob_cyc[0] : -1, W + 2);
    end else begin
      tests_run++;
      if (ob_data[0] !== 16'hBEEF) begin
        tests_failed++;
        $display("FAIL fetch_data: got %h expected BEEF", ob_data[0]);
      end
    end
    tests_run++;
    if (ob_ce != W + 2 || ob_oe != W || ob_we != 0 || ob_viol != 0) begin
      tests_failed++;
      $display("FAIL fetch_strobes: got ce=%0d oe=%0d we=%0d viol=%0d expected %0d/%0d/0/0",
               ob_ce, ob_oe, ob_we, ob_viol, W + 2, W);
    end
    model_last = 0;
    $display("[TB] single fetch addr=0010 ce=%0d oe=%0d", ob_ce, ob_oe);
  endtask

  task automatic test_single_write();
    int bad_addr, bad_wd;
    repeat (2) @(negedge clk);
    bus.d_addr = 16'h8000; bus.d_wdata = 16'h1234; bus.d_write = 1'b1;
    observe(1, 20, 0, 1);
    tests_run++;
    if (ob_port.size() != 1 || ob_port[0] != 1 || ob_cyc[0] != W + 2) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d events (first cycle %0d) expected 1 data ready at %0d",
               ob_port.size(), ob_cyc.size() > 0 ? ob_cyc[0] : -1, W + 2);
    end
    bad_addr = 0; bad_wd = 0;
    foreach (ob_addr[j]) if (ob_addr[j] !== 16'h8000) bad_addr++;
    foreach (ob_wd[j])   if (ob_wd[j] !== 16'h1234) bad_wd++;
    tests_run++;
    if (ob_we != W || ob_oe != 0 || ob_ce != W + 2 || bad_addr != 0 || bad_wd != 0 || ob_viol != 0) begin
      tests_failed++;
      $display("FAIL write_strobes: got we=%0d oe=%0d ce=%0d bad_addr=%0d bad_wdata=%0d viol=%0d expected %0d/0/%0d/0/0/0",
               ob_we, ob_oe, ob_ce, bad_addr, bad_wd, ob_viol, W, W + 2);
    end
    shadow[16'h8000] = 16'h1234;
    model_last = 1;
    $display("[TB] single write addr=8000 data=1234 we=%0d", ob_we);

    repeat (2) @(negedge clk);
    bus.d_addr = 16'h8000; bus.d_read = 1'b1;
    observe(1, 20, 0, 0);
    tests_run++;
    if (ob_port.size() != 1 || ob_data[0] !== model_read(16'h8000)) begin
      tests_failed++;
      $display("FAIL write_readback: got %h expected %h",
               ob_data.size() > 0 ? ob_data[0] : 16'hxxxx, model_read(16'h8000));
    end
    model_last = 1;
    $display("[TB] readback addr=8000");
  endtask

  task automatic test_contention();
    logic [15:0] a, b;
    int exp_port;
    repeat (2) @(negedge clk);
    a = 16'($urandom); b = 16'($urandom);
    bus.i_addr = a; bus.d_addr = b; bus.i_req = 1'b1; bus.d_read = 1'b1;
    observe(4, 40, 1, 0);
    tests_run++;
    if (ob_port.size() != 4) begin
      tests_failed++;
      $display("FAIL contention_count: got %0d completions expected 4", ob_port.size());
    end
    exp_port = (model_last == 0) ? 1 : 0;
    for (int e = 0; e < ob_port.size() && e < 4; e++) begin
      tests_run++;
      if (ob_port[e] != exp_port || ob_cyc[e] != (e + 1) * (W + 2) ||
          ob_data[e] !== model_read(exp_port == 0 ? a : b)) begin
        tests_failed++;
        $display("FAIL contention_%0d: got port=%0d cyc=%0d data=%h expected port=%0d cyc=%0d data=%h",
                 e, ob_port[e], ob_cyc[e], ob_data[e], exp_port, (e + 1) * (W + 2),
                 model_read(exp_port == 0 ? a : b));
      end
      $display("[TB] contention access %0d port=%0d cycle=%0d", e, ob_port[e], ob_cyc[e]);
      model_last = exp_port;
      exp_port = 1 - exp_port;
    end
    tests_run++;
    if (ob_gap != 0 || ob_viol != 0) begin
      tests_failed++;
      $display("FAIL contention_bubble: got idle=%0d viol=%0d expected 0/0", ob_gap, ob_viol);
    end
  endtask

  task automatic test_rw_conflict();
    logic [15:0] r, c, x, prev;
    repeat (2) @(negedge clk);
    r = 16'($urandom_range(0, 255)); c = 16'h4000 | 16'($urandom_range(0, 255)); x = 16'($urandom);
    bus.d_addr = r; bus.d_read = 1'b1;
    observe(1, 20, 0, 0);
    prev = model_read(r);
    tests_run++;
    if (ob_port.size() != 1 || ob_data[0] !== prev) begin
      tests_failed++;
      $display("FAIL conflict_preread: got %h expected %h", ob_data.size() > 0 ? ob_data[0] : 16'hxxxx, prev);
    end
    model_last = 1;
    repeat (2) @(negedge clk);
    bus.d_addr = c; bus.d_wdata = x; bus.d_read = 1'b1; bus.d_write = 1'b1;
    observe(1, 20, 0, 0);
    tests_run++;
    if (ob_port.size() != 1 || ob_oe != 0 || ob_we != W || bus.d_rdata !== prev) begin
      tests_failed++;
      $display("FAIL conflict_write: got events=%0d oe=%0d we=%0d d_rdata=%h expected 1/0/%0d/%h",
               ob_port.size(), ob_oe, ob_we, bus.d_rdata, W, prev);
    end
    shadow[c] = x;
    repeat (2) @(negedge clk);
    bus.d_addr = c; bus.d_read = 1'b1;
    observe(1, 20, 0, 0);
    tests_run++;
    if (ob_port.size() != 1 || ob_data[0] !== x) begin
      tests_failed++;
      $display("FAIL conflict_readback: got %h expected %h", ob_data.size() > 0 ? ob_data[0] : 16'hxxxx, x);
    end
    $display("[TB] read+write conflict addr=%h data=%h", c, x);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    repeat (2) @(negedge clk);
    a = 16'($urandom);
    bus.i_addr = a; bus.i_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.mem_ce, bus.mem_oe, bus.mem_we, bus.i_ready, bus.d_ready} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_%0d: got ce/oe/we/ir/dr=%b expected 00000", k,
                 {bus.mem_ce, bus.mem_oe, bus.mem_we, bus.i_ready, bus.d_ready});
      end
    end
    rst = 1'b0;
    model_last = 1; model_last1 = 1;
    observe(1, 20, 0, 0);
    tests_run++;
    if (ob_port.size() != 1 || ob_port[0] != 0 || ob_cyc[0] != W + 2 || ob_data[0] !== model_read(a)) begin
      tests_failed++;
      $display("FAIL reset_restart: got events=%0d cyc=%0d data=%h expected fetch at %0d data=%h",
               ob_port.size(), ob_cyc.size() > 0 ? ob_cyc[0] : -1,
               ob_data.size() > 0 ? ob_data[0] : 16'hxxxx, W + 2, model_read(a));
    end
    model_last = 0;
    $display("[TB] reset mid-access, restart addr=%h", a);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int mode, op, n, reads;
      int order [2];
      bit do_i, do_d, scr;
      logic [15:0] ia, da, wd, prev_d, exp;
      repeat (2) @(negedge clk);
      mode = $urandom_range(0, 3);
      op   = $urandom_range(0, 2);
      do_i = (mode != 1);
      do_d = (mode != 0);
      ia = 16'($urandom_range(0, 15)); if ($urandom_range(0, 1) == 1) ia[15] = 1'b1;
      da = 16'($urandom_range(0, 15)); if ($urandom_range(0, 1) == 1) da[15] = 1'b1;
      wd = 16'($urandom);
      n  = int'(do_i) + int'(do_d);
      scr = (n == 1) && ($urandom_range(0, 1) == 1);
      reads = int'(do_i) + int'(do_d && op == 0);
      prev_d = bus.d_rdata;
      if (n == 2) begin
        order[0] = (model_last == 0) ? 1 : 0;
        order[1] = 1 - order[0];
      end else begin
        order[0] = do_i ? 0 : 1;
        order[1] = 0;
      end
      bus.i_addr = ia; bus.d_addr = da; bus.d_wdata = wd;
      bus.i_req = do_i; bus.d_read = do_d && op != 1; bus.d_write = do_d && op != 0;
      observe(n, 30, 0, scr);
      tests_run++;
      if (ob_port.size() != n) begin
        tests_failed++;
        $display("FAIL rand_%0d_count: got %0d completions expected %0d", it, ob_port.size(), n);
      end
      for (int e = 0; e < n && e < ob_port.size(); e++) begin
        if (order[e] == 0) exp = model_read(ia);
        else if (op == 0)  exp = model_read(da);
        else               exp = prev_d;
        tests_run++;
        if (ob_port[e] != order[e] || ob_cyc[e] != (e + 1) * (W + 2) || ob_data[e] !== exp) begin
          tests_failed++;
          $display("FAIL rand_%0d_ev%0d: got port=%0d cyc=%0d data=%h expected port=%0d cyc=%0d data=%h",
                   it, e, ob_port[e], ob_cyc[e], ob_data[e], order[e], (e + 1) * (W + 2), exp);
        end
        if (order[e] == 1 && op != 0) shadow[da] = wd;
      end
      tests_run++;
      if (ob_viol != 0 || ob_gap != 0 || ob_oe != W * reads || ob_we != ((do_d && op != 0) ? W : 0)) begin
        tests_failed++;
        $display("FAIL rand_%0d_strobes: got viol=%0d idle=%0d oe=%0d we=%0d expected 0/0/%0d/%0d",
                 it, ob_viol, ob_gap, ob_oe, ob_we, W * reads, (do_d && op != 0) ? W : 0);
      end
      model_last = order[n - 1];
      $display("[TB] random %0d: fetch=%0d data=%0d op=%0d ia=%h da=%h", it, do_i, do_d, op, ia, da);
    end
  endtask

  task automatic test_wait1();
    int lat, ce_n, oe_n, got;
    int ports [2];
    int cycs [2];
    logic [15:0] dat, a, b;
    logic [15:0] dats [2];
    int first;
    repeat (2) @(negedge clk);
    a = 16'($urandom);
    bus1.i_addr = a; bus1.i_req = 1'b1;
    lat = -1; ce_n = 0; oe_n = 0; dat = '0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (bus1.mem_ce) ce_n++;
      if (bus1.mem_oe) oe_n++;
      if (bus1.i_ready) begin lat = k; dat = bus1.i_data; bus1.i_req = 1'b0; end
    end
    tests_run++;
    if (lat != W1 + 2 || dat !== init_pat(a) || ce_n != W1 + 2 || oe_n != W1) begin
      tests_failed++;
      $display("FAIL wait1_fetch: got lat=%0d data=%h ce=%0d oe=%0d expected %0d/%h/%0d/%0d",
               lat, dat, ce_n, oe_n, W1 + 2, init_pat(a), W1 + 2, W1);
    end
    model_last1 = 0;
    $display("[TB] wait1 fetch addr=%h latency=%0d", a, lat);

    repeat (2) @(negedge clk);
    b = 16'($urandom);
    bus1.i_req = 1'b1; bus1.d_read = 1'b1; bus1.d_addr = b;
    got = 0;
    for (int k = 1; k <= 20 && got < 2; k++) begin
      @(negedge clk);
      if (bus1.i_ready) begin ports[got] = 0; cycs[got] = k; dats[got] = bus1.i_data; got++; bus1.i_req = 1'b0; end
      else if (bus1.d_ready) begin ports[got] = 1; cycs[got] = k; dats[got] = bus1.d_rdata; got++; bus1.d_read = 1'b0; end
    end
    bus1.i_req = 1'b0; bus1.d_read = 1'b0;
    first = (model_last1 == 0) ? 1 : 0;
    tests_run++;
    if (got != 2) begin
      tests_failed++;
      $display("FAIL wait1_b2b_count: got %0d completions expected 2", got);
    end else begin
      for (int e = 0; e < 2; e++) begin
        tests_run++;
        if (ports[e] != (e == 0 ? first : 1 - first) || cycs[e] != (e + 1) * (W1 + 2) ||
            dats[e] !== init_pat(ports[e] == 0 ? a : b)) begin
          tests_failed++;
          $display("FAIL wait1_b2b_%0d: got port=%0d cyc=%0d data=%h expected port=%0d cyc=%0d",
                   e, ports[e], cycs[e], dats[e], (e == 0 ? first : 1 - first), (e + 1) * (W1 + 2));
        end
      end
      model_last1 = 1 - first;
    end
    $display("[TB] wait1 back-to-back completions=%0d", got);
  endtask

  initial begin
    test_reset();
    test_wait1();
    test_single_fetch();
    test_single_write();
    test_contention();
    test_rw_conflict();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
